counter_sequencer: RTL and testbench

Control stage directly upstream of the 4-bit binary counter (load/d/enable/sync_clr interface).
On a start request it captures a start value, an end value, a prescale divisor and a mode. It then loads the counter and paces its enable at a programmable rate.
It watches the counter's q for the terminal value and either finishes (one-shot) or reloads and repeats (auto-reload). It reports busy, done and a wrap count.

---
 rtl/counter_seq_pkg.sv | 15 +
 rtl/counter_sequencer_enable_prescaler.sv | 30 +++
 rtl/counter_sequencer.sv | 124 ++++++++++++
 tb/tb_counter_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter sequencer slice.
// State encoding is fixed here so every stage agrees on it.
package counter_seq_pkg;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter_sequencer_enable_prescaler.sv
// Programmable enable divider: one tick every div+1 free cycles.
// clr wins over hold; hold freezes the count and masks the tick.
module enable_prescaler
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [WIDTH-1:0] div,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    assign tick = !clr && !hold && (cnt == div);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// Sequencer driving a binary counter: load, paced enable, terminal
// detection with one-shot or auto-reload, and a saturating wrap count.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              auto_reload,
    input  logic [WIDTH-1:0]  start_val,
    input  logic [WIDTH-1:0]  end_val,
    input  logic [WIDTH-1:0]  div,
    input  logic [WIDTH-1:0]  q_in,
    output logic              load,
    output logic [WIDTH-1:0]  d,
    output logic              enable,
    output logic              sync_clr,
    output logic              busy,
    output logic              done,
    output logic [WRAP_W-1:0] wrap_cnt
);

    localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] start_val_r;
    logic [WIDTH-1:0] end_val_r;
    logic [WIDTH-1:0] div_r;
    logic             auto_reload_r;

    logic terminal;
    logic capture;
    logic wrap_inc;
    logic pre_clr;
    logic pre_hold;
    logic tick;

    assign terminal = (q_in == end_val_r);

    enable_prescaler #(
        .WIDTH(WIDTH)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .clr (pre_clr),
        .hold(pre_hold),
        .div (div_r),
        .tick(tick)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        wrap_inc  = 1'b0;
        pre_clr   = 1'b0;
        pre_hold  = 1'b1;
        unique case (state)
            IDLE: begin
                if (!stop && start) begin
                    capture   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                pre_clr   = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (terminal) begin
                    if (auto_reload_r) begin
                        wrap_inc  = 1'b1;
                        state_nxt = LOAD;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (!pause) begin
                    pre_hold = 1'b0;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes are masked during reset so an abandoned run never touches the counter.
    assign load     = rst && (state == LOAD);
    assign enable   = rst && tick;
    assign sync_clr = rst && stop && (state != LOAD);
    assign done     = rst && (state == DONE) && !stop;
    assign busy     = (state != IDLE);
    assign d        = start_val_r;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            start_val_r   <= '0;
            end_val_r     <= '0;
            div_r         <= '0;
            auto_reload_r <= 1'b0;
            wrap_cnt      <= '0;
        end else begin
            state <= state_nxt;
            if (capture) begin
                start_val_r   <= start_val;
                end_val_r     <= end_val;
                div_r         <= div;
                auto_reload_r <= auto_reload;
                wrap_cnt      <= '0;
            end else if (wrap_inc && wrap_cnt != WRAP_MAX) begin
                wrap_cnt <= wrap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural 4-bit counter
// closing the q_in loop.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic       auto_reload = 1'b0;
    logic [3:0] start_val = '0;
    logic [3:0] end_val = '0;
    logic [3:0] div = '0;
    logic [3:0] q = '0;
    logic       load;
    logic [3:0] d;
    logic       enable;
    logic       sync_clr;
    logic       busy;
    logic       done;
    logic [7:0] wrap_cnt;

    int checks = 0;
    int errors = 0;

    counter_sequencer #(
        .WIDTH (4),
        .WRAP_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .auto_reload(auto_reload),
        .start_val  (start_val),
        .end_val    (end_val),
        .div        (div),
        .q_in       (q),
        .load       (load),
        .d          (d),
        .enable     (enable),
        .sync_clr   (sync_clr),
        .busy       (busy),
        .done       (done),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sync_clr)    q <= 4'd0;
        else if (load)   q <= d;
        else if (enable) q <= q + 4'd1;
    end

    typedef struct {
        logic       st, sp, pa, ar;
        logic [3:0] sv, ev, dv;
        logic       ld;
        logic [3:0] dd;
        logic       en, cl, bs, dn;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, sp, pa, ar,
                                input logic [3:0] sv, ev, dv,
                                input logic ld, input logic [3:0] dd,
                                input logic en, cl, bs, dn);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.ar = ar;
        v.sv = sv; v.ev = ev; v.dv = dv;
        v.ld = ld; v.dd = dd; v.en = en; v.cl = cl; v.bs = bs; v.dn = dn;
        return v;
    endfunction

    // Non-start row: config inputs carry junk that must be ignored.
    function automatic vec_t g(input logic sp, pa, ld, input logic [3:0] dd,
                               input logic en, cl, bs, dn);
        return mk(1'b0, sp, pa, 1'b1, 4'd9, 4'd9, 4'd7, ld, dd, en, cl, bs, dn);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, sp, pa, ar, input logic [3:0] sv, ev, dv);
        start = st; stop = sp; pause = pa; auto_reload = ar;
        start_val = sv; end_val = ev; div = dv;
    endtask

    initial begin
        // one-shot 3..6, div 0
        tbl.push_back(mk(1, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(g(0, 0, 1, 3, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 3, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 3, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 3, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 3, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 3, 0, 0, 1, 1));
        tbl.push_back(g(0, 0, 0, 3, 0, 0, 0, 0));
        // start == end
        tbl.push_back(mk(1, 0, 0, 0, 5, 5, 0, 0, 3, 0, 0, 0, 0));
        tbl.push_back(g(0, 0, 1, 5, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 5, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 5, 0, 0, 1, 1));
        tbl.push_back(g(0, 0, 0, 5, 0, 0, 0, 0));
        // prescale 0..2, div 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 2, 2, 0, 5, 0, 0, 0, 0));
        tbl.push_back(g(0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 0, 0));
        // wrap 14..1
        tbl.push_back(mk(1, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(g(0, 0, 1, 14, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 14, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 14, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 14, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 14, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 14, 0, 0, 1, 1));
        tbl.push_back(g(0, 0, 0, 14, 0, 0, 0, 0));
        // start + stop in idle
        tbl.push_back(mk(1, 1, 0, 0, 7, 7, 0, 0, 14, 0, 1, 0, 0));
        tbl.push_back(g(0, 0, 0, 14, 0, 0, 0, 0));
        // pause with held prescaler, then stop
        tbl.push_back(mk(1, 0, 0, 0, 0, 15, 1, 0, 14, 0, 0, 0, 0));
        tbl.push_back(g(0, 0, 1, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(g(0, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(g(1, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(g(0, 0, 0, 0, 0, 0, 0, 0));

        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_load", load, 0);
        chk("rst_en", enable, 0);
        chk("rst_clr", sync_clr, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_d", d, 0);
        chk("rst_wrap", wrap_cnt, 0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].st, tbl[i].sp, tbl[i].pa, tbl[i].ar,
                  tbl[i].sv, tbl[i].ev, tbl[i].dv);
            #1;
            chk($sformatf("row%0d_load", i), load, tbl[i].ld);
            chk($sformatf("row%0d_d", i), d, tbl[i].dd);
            chk($sformatf("row%0d_en", i), enable, tbl[i].en);
            chk($sformatf("row%0d_clr", i), sync_clr, tbl[i].cl);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bs);
            chk($sformatf("row%0d_done", i), done, tbl[i].dn);
            chk($sformatf("row%0d_wrap", i), wrap_cnt, 0);
        end

        // auto-reload 1..3 with div 0, run to saturation
        @(negedge clk);
        drive(1, 0, 0, 1, 1, 3, 0);
        for (int i = 1; i <= 1100; i++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 4'd9, 4'd9, 4'd7);
            #1;
            if (i <= 20) begin
                chk($sformatf("ar%0d_load", i), load, (i % 4) == 1);
                chk($sformatf("ar%0d_en", i), enable,
                    (i % 4) == 2 || (i % 4) == 3);
            end
            chk($sformatf("ar%0d_done", i), done, 0);
            chk($sformatf("ar%0d_wrap", i), wrap_cnt,
                ((i - 1) / 4 > 255) ? 255 : (i - 1) / 4);
        end

        // reset mid-run
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_load", load, 0);
        chk("mrst_en", enable, 0);
        chk("mrst_clr", sync_clr, 0);
        chk("mrst_done", done, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("prst_busy", busy, 0);
        chk("prst_wrap", wrap_cnt, 0);
        chk("prst_d", d, 0);
        chk("prst_load", load, 0);
        chk("prst_en", enable, 0);
        chk("prst_clr", sync_clr, 0);
        chk("prst_done", done, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle%0d_busy", i), busy, 0);
            chk($sformatf("idle%0d_done", i), done, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
